// File: rtl/ibus_axi_refill_bridge_if.sv
// Signal bundle between the ICache refill/uncached ports and the AXI read channel of the refill bridge.
// The "slave" modport is the bridge; "master" is the ICache requester together with the AXI slave.
interface ibus_axi_refill_bridge_if #(
    parameter int LINE_WORD_NUM = 4,
    parameter int ID_WIDTH      = 4
);
    logic                          ic_rd_req;
    logic [31:0]                   ic_rd_addr;
    logic                          ic_rd_rdy;
    logic                          ic_ret_valid;
    logic [32*LINE_WORD_NUM-1:0]   ic_ret_data;
    logic                          unc_rd_req;
    logic [31:0]                   unc_rd_addr;
    logic                          unc_rd_rdy;
    logic                          unc_ret_valid;
    logic [31:0]                   unc_ret_data;
    logic [ID_WIDTH-1:0]           arid;
    logic [31:0]                   araddr;
    logic [7:0]                    arlen;
    logic [2:0]                    arsize;
    logic [1:0]                    arburst;
    logic                          arvalid;
    logic                          arready;
    logic [ID_WIDTH-1:0]           rid;
    logic [1:0]                    rresp;
    logic [31:0]                   rdata;
    logic                          rlast;
    logic                          rvalid;
    logic                          rready;

    modport master (
        output ic_rd_req, ic_rd_addr, unc_rd_req, unc_rd_addr,
        output arready, rid, rresp, rdata, rlast, rvalid,
        input  ic_rd_rdy, ic_ret_valid, ic_ret_data, unc_rd_rdy, unc_ret_valid, unc_ret_data,
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready
    );

    modport slave (
        input  ic_rd_req, ic_rd_addr, unc_rd_req, unc_rd_addr,
        input  arready, rid, rresp, rdata, rlast, rvalid,
        output ic_rd_rdy, ic_ret_valid, ic_ret_data, unc_rd_rdy, unc_ret_valid, unc_ret_data,
        output arid, araddr, arlen, arsize, arburst, arvalid, rready
    );
endinterface

// File: rtl/ibus_axi_refill_bridge.sv
// ICache refill / uncached instruction fetch to AXI4 read bridge: one transaction at a time,
// refills as INCR bursts of LINE_WORD_NUM beats, uncached reads as single beats.
module ibus_axi_refill_bridge #(
    parameter int LINE_WORD_NUM = 4,
    parameter int ID_WIDTH      = 4,
    parameter int AXI_ID        = 0
) (
    input  logic                    clk,
    input  logic                    resetn,
    ibus_axi_refill_bridge_if.slave bus
);
    localparam int                CNT_W    = $clog2(LINE_WORD_NUM) + 1;
    localparam int                IDX_W    = CNT_W - 1;
    localparam logic [31:0]       OFF_MASK = 32'(4 * LINE_WORD_NUM - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(LINE_WORD_NUM);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                          state_r;
    state_t                          state_s;
    logic [31:0]                     araddr_r;
    logic [7:0]                      arlen_r;
    logic                            is_ic_r;
    logic [CNT_W-1:0]                cnt_r;
    logic [LINE_WORD_NUM-1:0][31:0]  line_r;
    logic [LINE_WORD_NUM-1:0][31:0]  line_s;
    logic [LINE_WORD_NUM-1:0][31:0]  ic_ret_data_r;
    logic [31:0]                     unc_ret_data_r;
    logic                            ic_ret_valid_r;
    logic                            unc_ret_valid_r;
    logic                            ic_grant_s;
    logic                            unc_grant_s;
    logic                            beat_s;
    logic                            last_beat_s;
    logic                            wr_en_s;
    logic                            unused_s;

    // rid/rresp carry no information with a single outstanding read
    assign unused_s    = ^{bus.rid, bus.rresp};
    assign beat_s      = (state_r == S_R) && bus.rvalid;
    assign last_beat_s = beat_s && bus.rlast;
    assign wr_en_s     = beat_s && (cnt_r < CNT_FULL);

    // Next-state decode and request grants; the refill port has priority
    always_comb begin
        state_s     = state_r;
        ic_grant_s  = 1'b0;
        unc_grant_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (bus.ic_rd_req) begin
                    ic_grant_s = 1'b1;
                    state_s    = S_AR;
                end else if (bus.unc_rd_req) begin
                    unc_grant_s = 1'b1;
                    state_s     = S_AR;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_AR: begin
                if (bus.arready) begin
                    state_s = S_R;
                end else begin
                    state_s = S_AR;
                end
            end
            S_R: begin
                if (last_beat_s) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_R;
                end
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Line buffer with the current beat merged in; beats past the end of the line are dropped
    always_comb begin
        line_s = line_r;
        if (wr_en_s) begin
            line_s[cnt_r[IDX_W-1:0]] = bus.rdata;
        end else begin
            line_s = line_r;
        end
    end

    // State, request capture, beat assembly and registered return outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r         <= S_IDLE;
            araddr_r        <= 32'h0000_0000;
            arlen_r         <= 8'h00;
            is_ic_r         <= 1'b0;
            cnt_r           <= '0;
            line_r          <= '0;
            ic_ret_data_r   <= '0;
            unc_ret_data_r  <= 32'h0000_0000;
            ic_ret_valid_r  <= 1'b0;
            unc_ret_valid_r <= 1'b0;
        end else begin
            state_r         <= state_s;
            ic_ret_valid_r  <= last_beat_s && is_ic_r;
            unc_ret_valid_r <= last_beat_s && !is_ic_r;
            if (ic_grant_s) begin
                araddr_r <= bus.ic_rd_addr & ~OFF_MASK;
                arlen_r  <= 8'(LINE_WORD_NUM - 1);
                is_ic_r  <= 1'b1;
                cnt_r    <= '0;
                line_r   <= '0;
            end else if (unc_grant_s) begin
                araddr_r <= bus.unc_rd_addr;
                arlen_r  <= 8'h00;
                is_ic_r  <= 1'b0;
                cnt_r    <= '0;
                line_r   <= '0;
            end else if (wr_en_s) begin
                line_r <= line_s;
                cnt_r  <= cnt_r + CNT_W'(1);
            end
            // Return data is latched only on completion so it holds between transactions
            if (last_beat_s && is_ic_r) begin
                ic_ret_data_r <= line_s;
            end
            if (last_beat_s && !is_ic_r) begin
                unc_ret_data_r <= line_s[0];
            end
        end
    end

    assign bus.ic_rd_rdy     = ic_grant_s;
    assign bus.unc_rd_rdy    = unc_grant_s;
    assign bus.ic_ret_valid  = ic_ret_valid_r;
    assign bus.ic_ret_data   = ic_ret_data_r;
    assign bus.unc_ret_valid = unc_ret_valid_r;
    assign bus.unc_ret_data  = unc_ret_data_r;
    assign bus.arid          = ID_WIDTH'(AXI_ID);
    assign bus.araddr        = araddr_r;
    assign bus.arlen         = arlen_r;
    assign bus.arsize        = 3'b010;
    assign bus.arburst       = 2'b01;
    assign bus.arvalid       = (state_r == S_AR);
    assign bus.rready        = (state_r == S_R);
endmodule

// File: tb/tb_ibus_axi_refill_bridge.sv
// Bench for ibus_axi_refill_bridge: directed vector table, hand-written corner sequences and
// randomized transactions checked against a line-level model of the expected AXI/ICache behaviour.
module tb_ibus_axi_refill_bridge;
    localparam int LWN = 4;
    localparam int LW  = 32 * LWN;

    typedef struct {
        bit          is_ic;
        logic [31:0] addr;
        int          ar_delay;
        int          gap;
        int          nbeats;
        logic [31:0] seed;
        logic [31:0] exp_araddr;
        logic [7:0]  exp_arlen;
        string       name;
    } vec_t;

    logic          clk = 1'b0;
    logic          resetn;
    int            total;
    int            bad;
    logic [LW-1:0] last_ic;
    logic [31:0]   last_unc;

    always #5 clk = ~clk;

    ibus_axi_refill_bridge_if #(.LINE_WORD_NUM(LWN), .ID_WIDTH(4)) bus ();

    ibus_axi_refill_bridge #(.LINE_WORD_NUM(LWN), .ID_WIDTH(4), .AXI_ID(5)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Line-aligned base computed arithmetically from the line size in bytes
    function automatic logic [31:0] line_base(input logic [31:0] a);
        return (a / 32'(4 * LWN)) * 32'(4 * LWN);
    endfunction

    // Words 0..nbeats-1 carry seed+i; anything not delivered stays zero
    function automatic logic [LW-1:0] exp_line(input logic [31:0] seed, input int nbeats);
        logic [LW-1:0] l;
        l = '0;
        for (int i = 0; i < LWN; i++) begin
            if (i < nbeats) l[32*i +: 32] = seed + 32'(i);
        end
        return l;
    endfunction

    // Plays requester and AXI slave for one transaction, starting and ending in an IDLE cycle
    task automatic run_txn(input bit is_ic, input logic [31:0] addr, input int ar_delay,
                           input int gap, input int nbeats, input logic [31:0] seed,
                           input logic [31:0] exp_araddr, input logic [7:0] exp_arlen,
                           input string tag);
        logic [LW-1:0] exp_data;
        exp_data = exp_line(seed, nbeats);
        if (is_ic) begin
            bus.ic_rd_req  = 1'b1;
            bus.ic_rd_addr = addr;
        end else begin
            bus.unc_rd_req  = 1'b1;
            bus.unc_rd_addr = addr;
        end
        #1;
        chk($sformatf("%s rdy", tag), LW'(is_ic ? bus.ic_rd_rdy : bus.unc_rd_rdy), LW'(1));
        chk($sformatf("%s other_rdy", tag), LW'(is_ic ? bus.unc_rd_rdy : bus.ic_rd_rdy), LW'(0));
        step();
        if (is_ic) bus.ic_rd_req = 1'b0;
        else       bus.unc_rd_req = 1'b0;
        for (int i = 0; i <= ar_delay; i++) begin
            bus.arready = (i == ar_delay);
            #1;
            chk($sformatf("%s arvalid", tag), LW'(bus.arvalid), LW'(1));
            chk($sformatf("%s araddr", tag), LW'(bus.araddr), LW'(exp_araddr));
            chk($sformatf("%s rdy_in_ar", tag), LW'(bus.ic_rd_rdy | bus.unc_rd_rdy), LW'(0));
            if (i == ar_delay) begin
                chk($sformatf("%s arlen", tag), LW'(bus.arlen), LW'(exp_arlen));
                chk($sformatf("%s arsize", tag), LW'(bus.arsize), LW'(2));
                chk($sformatf("%s arburst", tag), LW'(bus.arburst), LW'(1));
                chk($sformatf("%s arid", tag), LW'(bus.arid), LW'(5));
            end
            step();
        end
        bus.arready = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            for (int g = 0; g < gap; g++) begin
                #1;
                chk($sformatf("%s rready_gap", tag), LW'(bus.rready), LW'(1));
                chk($sformatf("%s early_valid", tag), LW'(bus.ic_ret_valid | bus.unc_ret_valid), LW'(0));
                step();
            end
            bus.rvalid = 1'b1;
            bus.rdata  = seed + 32'(b);
            bus.rlast  = (b == nbeats - 1);
            #1;
            chk($sformatf("%s rready", tag), LW'(bus.rready), LW'(1));
            chk($sformatf("%s arvalid_in_r", tag), LW'(bus.arvalid), LW'(0));
            step();
            bus.rvalid = 1'b0;
            bus.rlast  = 1'b0;
        end
        #1;
        if (is_ic) last_ic = exp_data;
        else       last_unc = exp_data[31:0];
        chk($sformatf("%s ic_ret_valid", tag), LW'(bus.ic_ret_valid), LW'(is_ic));
        chk($sformatf("%s unc_ret_valid", tag), LW'(bus.unc_ret_valid), LW'(!is_ic));
        chk($sformatf("%s ic_ret_data", tag), bus.ic_ret_data, last_ic);
        chk($sformatf("%s unc_ret_data", tag), LW'(bus.unc_ret_data), LW'(last_unc));
        chk($sformatf("%s rready_done", tag), LW'(bus.rready), LW'(0));
        step();
        #1;
        chk($sformatf("%s valid_drop", tag), LW'(bus.ic_ret_valid | bus.unc_ret_valid), LW'(0));
        chk($sformatf("%s ic_hold", tag), bus.ic_ret_data, last_ic);
        chk($sformatf("%s unc_hold", tag), LW'(bus.unc_ret_data), LW'(last_unc));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[6];
        bit          r_ic;
        logic [31:0] r_addr;
        int          r_ad;
        int          r_gap;
        int          r_nb;

        vecs[0] = '{1'b1, 32'h1FC0_0014, 0, 0, 4, 32'h0000_00A0, 32'h1FC0_0010, 8'd3, "refill_basic"};
        vecs[1] = '{1'b0, 32'hBFD0_F000, 0, 0, 1, 32'h1234_5678, 32'hBFD0_F000, 8'd0, "uncached"};
        vecs[2] = '{1'b1, 32'h0000_1234, 5, 2, 4, 32'hC0DE_0000, 32'h0000_1230, 8'd3, "slow_slave"};
        vecs[3] = '{1'b1, 32'h8000_003C, 0, 0, 2, 32'h5555_0000, 32'h8000_0030, 8'd3, "early_rlast"};
        vecs[4] = '{1'b1, 32'h0000_0048, 1, 1, 5, 32'h7777_0000, 32'h0000_0040, 8'd3, "extra_beat"};
        vecs[5] = '{1'b0, 32'h0000_0104, 2, 1, 2, 32'h9999_0000, 32'h0000_0104, 8'd0, "unc_two_beats"};

        total = 0;
        bad = 0;
        last_ic = '0;
        last_unc = 32'h0;
        bus.ic_rd_req = 1'b0;   bus.ic_rd_addr = 32'h0;
        bus.unc_rd_req = 1'b0;  bus.unc_rd_addr = 32'h0;
        bus.arready = 1'b0;     bus.rid = 4'h0;   bus.rresp = 2'b00;
        bus.rdata = 32'h0;      bus.rlast = 1'b0; bus.rvalid = 1'b0;
        resetn = 1'b0;
        repeat (3) step();
        #1;
        chk("rst arvalid", LW'(bus.arvalid), LW'(0));
        chk("rst rready", LW'(bus.rready), LW'(0));
        chk("rst ret_valid", LW'(bus.ic_ret_valid | bus.unc_ret_valid), LW'(0));
        chk("rst rdy", LW'(bus.ic_rd_rdy | bus.unc_rd_rdy), LW'(0));
        chk("rst araddr", LW'(bus.araddr), LW'(0));
        chk("rst arlen", LW'(bus.arlen), LW'(0));
        chk("rst ic_ret_data", bus.ic_ret_data, LW'(0));
        chk("rst unc_ret_data", LW'(bus.unc_ret_data), LW'(0));
        resetn = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].is_ic, vecs[i].addr, vecs[i].ar_delay, vecs[i].gap, vecs[i].nbeats,
                    vecs[i].seed, vecs[i].exp_araddr, vecs[i].exp_arlen, vecs[i].name);
        end

        // Both requests together: refill first, held uncached request granted right after DONE
        bus.unc_rd_req  = 1'b1;
        bus.unc_rd_addr = 32'h0000_2000;
        run_txn(1'b1, 32'h0000_3004, 0, 0, 4, 32'hB000_0000, 32'h0000_3000, 8'd3, "arb_refill");
        run_txn(1'b0, 32'h0000_2000, 0, 0, 1, 32'hE000_0000, 32'h0000_2000, 8'd0, "arb_unc");

        // Reset in the middle of a refill burst
        bus.ic_rd_req  = 1'b1;
        bus.ic_rd_addr = 32'h2000_0008;
        #1;
        step();
        bus.ic_rd_req = 1'b0;
        bus.arready   = 1'b1;
        #1;
        step();
        bus.arready = 1'b0;
        bus.rvalid  = 1'b1;
        bus.rdata   = 32'hDEAD_BEEF;
        #1;
        chk("mid rready", LW'(bus.rready), LW'(1));
        step();
        resetn     = 1'b0;
        bus.rvalid = 1'b0;
        step();
        resetn = 1'b1;
        last_ic = '0;
        last_unc = 32'h0;
        #1;
        chk("mrst arvalid", LW'(bus.arvalid), LW'(0));
        chk("mrst rready", LW'(bus.rready), LW'(0));
        chk("mrst ret_valid", LW'(bus.ic_ret_valid | bus.unc_ret_valid), LW'(0));
        chk("mrst ic_ret_data", bus.ic_ret_data, LW'(0));
        bus.rvalid = 1'b1;
        bus.rlast  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("idle rready", LW'(bus.rready), LW'(0));
            chk("idle ret_valid", LW'(bus.ic_ret_valid | bus.unc_ret_valid), LW'(0));
            step();
        end
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        run_txn(1'b1, 32'h2000_0008, 0, 0, 4, 32'h4000_0000, 32'h2000_0000, 8'd3, "post_reset");

        for (int n = 0; n < 40; n++) begin
            r_ic   = ($urandom_range(0, 1) == 1);
            r_addr = $urandom;
            if (!r_ic) r_addr = r_addr & 32'hFFFF_FFFC;
            r_ad   = $urandom_range(0, 3);
            r_gap  = $urandom_range(0, 2);
            r_nb   = r_ic ? $urandom_range(1, LWN + 1) : $urandom_range(1, 2);
            run_txn(r_ic, r_addr, r_ad, r_gap, r_nb, $urandom,
                    r_ic ? line_base(r_addr) : r_addr, r_ic ? 8'(LWN - 1) : 8'd0,
                    $sformatf("rand%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
